// File: rtl/ahbl_sram_slave.sv
// ---------------------------------------------------------------------------
// ahbl_sram_slave
//   AHB-Lite responder backed by on-chip word memory. Handles byte/halfword/
//   word reads and writes with byte-lane merging. Inserts a programmable
//   number of wait states on OKAY beats. Returns the two-cycle ERROR
//   response for illegal sizes, misaligned addresses and out-of-range
//   addresses.
//
// Parameters
//   ADDR_WIDTH   haddr width
//   DATA_WIDTH   data bus width (only 32 supported)
//   MEM_DEPTH    memory size in 32-bit words, power of two
//   WAIT_STATES  hreadyout low cycles per OKAY data phase, 0..7
//
// Ports
//   sys_clk_i    clock, rising edge
//   sys_rstn_i   synchronous active-low reset
//   hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i    address-phase control
//   hburst_i, hprot_i, hmastlock_i                  accepted but ignored
//   hwdata_i     write data (data phase)
//   hready_i     bus HREADY
//   hrdata_o, hreadyout_o, hresp_o                  data-phase response
// ---------------------------------------------------------------------------
module ahbl_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rstn_i,
    input  logic                  hsel_i,
    input  logic [ADDR_WIDTH-1:0] haddr_i,
    input  logic [1:0]            htrans_i,
    input  logic                  hwrite_i,
    input  logic [2:0]            hsize_i,
    input  logic [2:0]            hburst_i,
    input  logic [3:0]            hprot_i,
    input  logic                  hmastlock_i,
    input  logic [DATA_WIDTH-1:0] hwdata_i,
    input  logic                  hready_i,
    output logic [DATA_WIDTH-1:0] hrdata_o,
    output logic                  hreadyout_o,
    output logic                  hresp_o
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-3:0] DEPTH_LIMIT = (ADDR_WIDTH-2)'(MEM_DEPTH);
    localparam logic [2:0] WAIT_INIT = 3'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                  state_reg;
    logic [2:0]              wait_cnt_reg;
    logic [IDX_W-1:0]        addr_idx_reg;
    logic [3:0]              be_reg;
    logic                    write_reg;
    logic                    pending_reg;     // legal data phase in progress
    logic                    rd_phase_reg;    // current cycle is final OKAY read cycle
    logic                    hreadyout_reg;
    logic                    hresp_reg;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]   rd_word_reg;
    logic [3:0]              fwd_be_reg;
    logic [DATA_WIDTH-1:0]   fwd_data_reg;
    logic [DATA_WIDTH-1:0]   rd_merged;

    logic                    accept;
    logic                    illegal;
    logic [3:0]              be_next;
    logic [IDX_W-1:0]        rd_index;
    logic                    wr_en;
    logic                    unused_ok;

    assign unused_ok = ^{htrans_i[0], hburst_i, hprot_i, hmastlock_i};

    // New address phases are only taken while this slave is itself ready,
    // so a stalled data phase can never be overlapped.
    assign accept = hsel_i & htrans_i[1] & hready_i & hreadyout_reg;

    always_comb begin
        illegal = 1'b0;
        if (hsize_i > 3'b010)
            illegal = 1'b1;
        if ((hsize_i == 3'b001) && haddr_i[0])
            illegal = 1'b1;
        if ((hsize_i == 3'b010) && (haddr_i[1:0] != 2'b00))
            illegal = 1'b1;
        if (haddr_i[ADDR_WIDTH-1:2] >= DEPTH_LIMIT)
            illegal = 1'b1;
    end

    always_comb begin
        case (hsize_i[1:0])
            2'b00:   be_next = 4'b0001 << haddr_i[1:0];
            2'b01:   be_next = haddr_i[1] ? 4'b1100 : 4'b0011;
            default: be_next = 4'b1111;
        endcase
    end

    // A write commits on the edge that ends its final OKAY data-phase cycle.
    // Reset on that edge aborts it.
    assign wr_en = sys_rstn_i & pending_reg & write_reg & (state_reg == ST_IDLE);

    // With zero wait states the read must be launched on the accepting edge;
    // otherwise the latched index keeps the RAM output current through WAIT.
    assign rd_index = accept ? haddr_i[IDX_W+1:2] : addr_idx_reg;

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rstn_i) begin
            state_reg     <= ST_IDLE;
            wait_cnt_reg  <= 3'd0;
            addr_idx_reg  <= '0;
            be_reg        <= 4'b0000;
            write_reg     <= 1'b0;
            pending_reg   <= 1'b0;
            rd_phase_reg  <= 1'b0;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= 1'b0;
        end else begin
            rd_phase_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_ERR2: begin
                    state_reg     <= ST_IDLE;
                    pending_reg   <= 1'b0;
                    hreadyout_reg <= 1'b1;
                    hresp_reg     <= 1'b0;
                    if (accept) begin
                        addr_idx_reg <= haddr_i[IDX_W+1:2];
                        be_reg       <= be_next;
                        write_reg    <= hwrite_i;
                        if (illegal) begin
                            state_reg     <= ST_ERR1;
                            hreadyout_reg <= 1'b0;
                            hresp_reg     <= 1'b1;
                        end else begin
                            pending_reg <= 1'b1;
                            if (WAIT_STATES > 0) begin
                                state_reg     <= ST_WAIT;
                                wait_cnt_reg  <= WAIT_INIT;
                                hreadyout_reg <= 1'b0;
                            end else begin
                                rd_phase_reg <= ~hwrite_i;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_reg == 3'd0) begin
                        state_reg     <= ST_IDLE;
                        hreadyout_reg <= 1'b1;
                        rd_phase_reg  <= ~write_reg;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 3'd1;
                    end
                end
                ST_ERR1: begin
                    state_reg     <= ST_ERR2;
                    hreadyout_reg <= 1'b1;
                    hresp_reg     <= 1'b1;
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    hreadyout_reg <= 1'b1;
                    hresp_reg     <= 1'b0;
                end
            endcase
        end
    end

    // Memory: byte-lane write plus registered read (read-before-write).
    always_ff @(posedge sys_clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be_reg[b])
                    mem[addr_idx_reg][b*8 +: 8] <= hwdata_i[b*8 +: 8];
            end
        end
        rd_word_reg <= mem[rd_index];
    end

    // A read accepted on the same edge as a write to the same word sees the
    // old RAM word; remember which lanes were just written so they can be
    // substituted on the output.
    always_ff @(posedge sys_clk_i) begin
        fwd_be_reg   <= (wr_en && (addr_idx_reg == rd_index)) ? be_reg : 4'b0000;
        fwd_data_reg <= hwdata_i;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_merged[gi*8 +: 8] = fwd_be_reg[gi] ? fwd_data_reg[gi*8 +: 8]
                                                         : rd_word_reg[gi*8 +: 8];
        end
    endgenerate

    assign hrdata_o    = rd_phase_reg ? rd_merged : '0;
    assign hreadyout_o = hreadyout_reg;
    assign hresp_o     = hresp_reg;

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahbl_sram_slave
//   Two slave instances (zero and three wait states) on a shared bus, each
//   with its own select and HREADY loop. A driver issues pipelined AHB-Lite
//   transfers and pushes the hand-computed response into a per-slave queue;
//   a monitor watches each slave's data phases and pops/compares whenever a
//   data phase completes.
// ---------------------------------------------------------------------------
module tb_ahbl_sram_slave;

    localparam int DEPTH = 64;

    typedef struct {
        bit          resp;
        int          waits;
        logic [31:0] data;
        string       name;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic [1:0]  hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [1:0]  hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata [2];

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   pend [2];
    int   wcnt [2];
    int   ecnt [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ahbl_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .sys_clk_i   (clk),
        .sys_rstn_i  (rstn),
        .hsel_i      (hsel[0]),
        .haddr_i     (haddr),
        .htrans_i    (htrans),
        .hwrite_i    (hwrite),
        .hsize_i     (hsize),
        .hburst_i    (3'b000),
        .hprot_i     (4'b0011),
        .hmastlock_i (1'b0),
        .hwdata_i    (hwdata),
        .hready_i    (hreadyout[0]),
        .hrdata_o    (hrdata[0]),
        .hreadyout_o (hreadyout[0]),
        .hresp_o     (hresp[0])
    );

    ahbl_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
        .sys_clk_i   (clk),
        .sys_rstn_i  (rstn),
        .hsel_i      (hsel[1]),
        .haddr_i     (haddr),
        .htrans_i    (htrans),
        .hwrite_i    (hwrite),
        .hsize_i     (hsize),
        .hburst_i    (3'b000),
        .hprot_i     (4'b0011),
        .hmastlock_i (1'b0),
        .hwdata_i    (hwdata),
        .hready_i    (hreadyout[1]),
        .hrdata_o    (hrdata[1]),
        .hreadyout_o (hreadyout[1]),
        .hresp_o     (hresp[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    // Issue one transfer on slave d (0: zero-wait, 1: three-wait). Returns
    // just after the accepting edge with hwdata set for the data phase, so
    // the next call overlaps its address phase with this data phase.
    task automatic issue(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] wd, input bit err, input logic [31:0] rd,
                         input string nm, input bit track);
        exp_t e;
        bit   rdy;
        int   guard;
        hsel   = (d == 0) ? 2'b01 : 2'b10;
        htrans = 2'b10;
        haddr  = a;
        hwrite = wr;
        hsize  = sz;
        if (track) begin
            e.resp  = err;
            e.waits = err ? 0 : ((d == 0) ? 0 : 3);
            e.data  = (err || wr) ? 32'h0 : rd;
            e.name  = nm;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        guard = 0;
        rdy   = 1'b0;
        while (!rdy && guard < 64) begin
            @(negedge clk);
            rdy = hreadyout[d];
            @(posedge clk);
            #1;
            guard++;
        end
        if (!rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s accept timeout: hready stayed 0, required 1", nm);
        end
        hwdata = wr ? wd : 32'h0;
    endtask

    task automatic go_idle();
        hsel   = 2'b00;
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    // Monitor: tracks each slave's data phase from bus signals only.
    always @(negedge clk) begin
        exp_t e;
        int   qsz;
        for (int i = 0; i < 2; i++) begin
            if (!rstn) begin
                pend[i] = 1'b0;
                wcnt[i] = 0;
                ecnt[i] = 0;
            end else begin
                if (pend[i]) begin
                    if (!hreadyout[i]) begin
                        if (hresp[i]) ecnt[i]++;
                        else          wcnt[i]++;
                    end else begin
                        qsz = (i == 0) ? q0.size() : q1.size();
                        if (qsz == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL slave%0d unexpected completion: got resp %0d, required none", i, hresp[i]);
                        end else begin
                            e = (i == 0) ? q0.pop_front() : q1.pop_front();
                            chk({e.name, " hresp"}, {31'b0, hresp[i]}, {31'b0, e.resp});
                            chk({e.name, " hrdata"}, hrdata[i], e.data);
                            chk({e.name, " wait cycles"}, wcnt[i], e.waits);
                            chk({e.name, " err1 cycles"}, ecnt[i], e.resp ? 32'd1 : 32'd0);
                        end
                    end
                end
                if (hreadyout[i]) begin
                    pend[i] = hsel[i] & htrans[1];
                    wcnt[i] = 0;
                    ecnt[i] = 0;
                end
            end
        end
    end

    initial begin
        int guard;
        rstn   = 1'b0;
        hsel   = 2'b00;
        haddr  = 32'h0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'b010;
        hwdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset slave%0d hreadyout", i), {31'b0, hreadyout[i]}, 32'd1);
            chk($sformatf("reset slave%0d hresp", i), {31'b0, hresp[i]}, 32'd0);
            chk($sformatf("reset slave%0d hrdata", i), hrdata[i], 32'h0);
        end
        @(posedge clk);
        #1 rstn = 1'b1;

        // Zero-wait slave: back-to-back pipelined traffic.
        issue(0, 1, 32'h10,  3'b010, 32'hDEADBEEF, 0, 32'h0,        "w0 W 0x10 word",        1);
        issue(0, 0, 32'h10,  3'b010, 32'h0,        0, 32'hDEADBEEF, "w0 R 0x10 after write", 1);
        issue(0, 1, 32'h13,  3'b000, 32'h5A000000, 0, 32'h0,        "w0 W 0x13 byte",        1);
        issue(0, 0, 32'h10,  3'b010, 32'h0,        0, 32'h5AADBEEF, "w0 R 0x10 after byte",  1);
        issue(0, 1, 32'h10,  3'b001, 32'h00001234, 0, 32'h0,        "w0 W 0x10 half",        1);
        issue(0, 0, 32'h10,  3'b010, 32'h0,        0, 32'h5AAD1234, "w0 R 0x10 after half",  1);
        issue(0, 1, 32'h00,  3'b010, 32'hCAFEF00D, 0, 32'h0,        "w0 W 0x00 word",        1);
        issue(0, 0, 32'h02,  3'b010, 32'h0,        1, 32'h0,        "w0 R 0x02 misaligned",  1);
        issue(0, 0, 32'h00,  3'b010, 32'h0,        0, 32'hCAFEF00D, "w0 R 0x00 after err",   1);
        issue(0, 1, DEPTH*4, 3'b010, 32'hBAD0BAD0, 1, 32'h0,        "w0 W out of range",     1);
        issue(0, 0, 32'h00,  3'b010, 32'h0,        0, 32'hCAFEF00D, "w0 R 0x00 in ERR2",     1);
        issue(0, 0, 32'h01,  3'b001, 32'h0,        1, 32'h0,        "w0 R 0x01 half misal",  1);
        issue(0, 0, 32'h04,  3'b011, 32'h0,        1, 32'h0,        "w0 R 0x04 bad size",    1);
        issue(0, 1, 32'h12,  3'b001, 32'h77660000, 0, 32'h0,        "w0 W 0x12 upper half",  1);
        issue(0, 0, 32'h11,  3'b000, 32'h0,        0, 32'h77661234, "w0 R 0x11 byte",        1);
        go_idle();
        repeat (4) @(posedge clk);
        #1;

        // Three-wait slave.
        issue(1, 1, 32'h20,  3'b010, 32'h11223344, 0, 32'h0,        "w3 W 0x20 word",        1);
        issue(1, 0, 32'h20,  3'b010, 32'h0,        0, 32'h11223344, "w3 R 0x20 word",        1);
        issue(1, 0, 32'h21,  3'b010, 32'h0,        1, 32'h0,        "w3 R 0x21 misaligned",  1);
        issue(1, 1, 32'h20,  3'b010, 32'hFFFFFFFF, 0, 32'h0,        "w3 W 0x20 aborted",     0);
        // Reset lands during the first wait cycle of the write above.
        rstn = 1'b0;
        go_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("midreset slave%0d hreadyout", i), {31'b0, hreadyout[i]}, 32'd1);
            chk($sformatf("midreset slave%0d hresp", i), {31'b0, hresp[i]}, 32'd0);
            chk($sformatf("midreset slave%0d hrdata", i), hrdata[i], 32'h0);
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        issue(1, 0, 32'h20,  3'b010, 32'h0,        0, 32'h11223344, "w3 R 0x20 after reset", 1);
        go_idle();

        guard = 0;
        while ((q0.size() != 0 || q1.size() != 0) && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain timeout: %0d responses outstanding, required 0", q0.size() + q1.size());
        end
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
